// File: rtl/async_fifo_if.sv
// Push/pop handshake bundle for async_fifo: the master is the user side,
// the slave is the FIFO itself.
interface async_fifo_if #(
  parameter int DSIZE = 8
);
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             awfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             arempty;

  modport master (
    output winc, wdata, rinc,
    input  wfull, awfull, rdata, rempty, arempty
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, awfull, rdata, rempty, arempty
  );
endinterface

// File: rtl/async_fifo.sv
// Single-clock first-word-fall-through circular FIFO for Hyperbus command/data queues.
// Define ASYNC_FIFO_ALMOST_EN to build the awfull/arempty almost flags; otherwise they read 0.
module async_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input logic         wclk,
  input logic         wrst_n,
  async_fifo_if.slave bus
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so equal low bits can mean either empty or full.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]) && (wptr[ASIZE] != rptr[ASIZE]);
  assign do_push = bus.winc && !full;
  assign do_pop  = bus.rinc && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge wclk) begin
    if (do_push) mem[wptr[ASIZE-1:0]] <= bus.wdata;
  end

  assign bus.rdata  = mem[rptr[ASIZE-1:0]];
  assign bus.rempty = empty;
  assign bus.wfull  = full;

`ifdef ASYNC_FIFO_ALMOST_EN
  localparam logic [ASIZE:0] ALMOST_FULL_LVL  = (ASIZE+1)'(DEPTH - 1);
  localparam logic [ASIZE:0] ALMOST_EMPTY_LVL = (ASIZE+1)'(1);

  logic [ASIZE:0] count;

  // Modular subtraction stays correct across pointer wrap.
  assign count       = wptr - rptr;
  assign bus.awfull  = (count >= ALMOST_FULL_LVL);
  assign bus.arempty = (count <= ALMOST_EMPTY_LVL);
`else
  assign bus.awfull  = 1'b0;
  assign bus.arempty = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo (DSIZE=8, ASIZE=2, DEPTH=4).
// Almost-flag expectations collapse to 0 when ASYNC_FIFO_ALMOST_EN is not defined.
module tb_async_fifo;

`ifdef ASYNC_FIFO_ALMOST_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  logic wclk;
  logic wrst_n;
  int   checks = 0;
  int   passes = 0;

  async_fifo_if #(.DSIZE(8)) bus ();

  async_fifo #(.DSIZE(8), .ASIZE(2)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Flag vector order: {rempty, arempty, wfull, awfull}.
  function automatic logic [3:0] exp_flags(input bit re, input bit ae, input bit wf, input bit af);
    return {re, ae & ALM, wf, af & ALM};
  endfunction

  function automatic logic [3:0] act_flags();
    return {bus.rempty, bus.arempty, bus.wfull, bus.awfull};
  endfunction

  // One clock with the given request inputs; outputs settle 1 ns after the edge.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r);
    bus.winc  = w;
    bus.wdata = d;
    bus.rinc  = r;
    @(posedge wclk);
    #1;
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.wdata = 8'h00;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    bus.winc = 1'b0; bus.rinc = 1'b0; bus.wdata = 8'h00;
    wrst_n = 1'b0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    e = exp_flags(1, 1, 0, 0);
    checks++;
    if (act_flags() !== e) $display("FAIL reset_idle flags got %b want %b", act_flags(), e);
    else passes++;
  endtask

  task automatic test_fill();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] fl   [4];
    fl[0] = exp_flags(0, 1, 0, 0);
    fl[1] = exp_flags(0, 0, 0, 0);
    fl[2] = exp_flags(0, 0, 0, 1);
    fl[3] = exp_flags(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, vals[i], 1'b0);
      checks++;
      if (act_flags() !== fl[i]) $display("FAIL fill_flags[%0d] got %b want %b", i, act_flags(), fl[i]);
      else passes++;
      checks++;
      if (bus.rdata !== 8'h11) $display("FAIL fill_rdata[%0d] got %h want 11", i, bus.rdata);
      else passes++;
    end
    cycle(1'b1, 8'h55, 1'b0);
    checks++;
    if (act_flags() !== fl[3]) $display("FAIL push_full_flags got %b want %b", act_flags(), fl[3]);
    else passes++;
    checks++;
    if (bus.rdata !== 8'h11) $display("FAIL push_full_rdata got %h want 11", bus.rdata);
    else passes++;
  endtask

  task automatic test_drain();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] fl   [4];
    fl[0] = exp_flags(0, 0, 0, 1);
    fl[1] = exp_flags(0, 0, 0, 0);
    fl[2] = exp_flags(0, 1, 0, 0);
    fl[3] = exp_flags(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.rdata !== vals[i]) $display("FAIL drain_rdata[%0d] got %h want %h", i, bus.rdata, vals[i]);
      else passes++;
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (act_flags() !== fl[i]) $display("FAIL drain_flags[%0d] got %b want %b", i, act_flags(), fl[i]);
      else passes++;
    end
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (act_flags() !== fl[3]) $display("FAIL pop_empty_flags got %b want %b", act_flags(), fl[3]);
    else passes++;
  endtask

  task automatic test_stream();
    logic [3:0] one = exp_flags(0, 1, 0, 0);
    cycle(1'b1, 8'h00, 1'b0);
    for (int i = 1; i < 10; i++) begin
      checks++;
      if (bus.rdata !== 8'(i - 1)) $display("FAIL stream_head[%0d] got %h want %h", i, bus.rdata, 8'(i - 1));
      else passes++;
      cycle(1'b1, 8'(i), 1'b1);
      checks++;
      if (act_flags() !== one) $display("FAIL stream_flags[%0d] got %b want %b", i, act_flags(), one);
      else passes++;
    end
    checks++;
    if (bus.rdata !== 8'h09) $display("FAIL stream_last got %h want 09", bus.rdata);
    else passes++;
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (act_flags() !== exp_flags(1, 1, 0, 0)) $display("FAIL stream_drained flags got %b", act_flags());
    else passes++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] rest [3] = '{8'h02, 8'h03, 8'h04};
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0);
    checks++;
    if (act_flags() !== exp_flags(0, 0, 1, 1)) $display("FAIL simul_prefull flags got %b", act_flags());
    else passes++;
    cycle(1'b1, 8'hAA, 1'b1);
    checks++;
    if (act_flags() !== exp_flags(0, 0, 0, 1)) $display("FAIL simul_full flags got %b want %b", act_flags(), exp_flags(0, 0, 0, 1));
    else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.rdata !== rest[i]) $display("FAIL simul_full_rdata[%0d] got %h want %h", i, bus.rdata, rest[i]);
      else passes++;
      cycle(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (act_flags() !== exp_flags(1, 1, 0, 0)) $display("FAIL simul_full_noaa flags got %b", act_flags());
    else passes++;
    cycle(1'b1, 8'hBB, 1'b1);
    checks++;
    if (act_flags() !== exp_flags(0, 1, 0, 0)) $display("FAIL simul_empty flags got %b want %b", act_flags(), exp_flags(0, 1, 0, 0));
    else passes++;
    checks++;
    if (bus.rdata !== 8'hBB) $display("FAIL simul_empty_rdata got %h want bb", bus.rdata);
    else passes++;
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_async_reset();
    logic [3:0] rst_fl = exp_flags(1, 1, 0, 0);
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    checks++;
    if (act_flags() !== exp_flags(0, 0, 0, 0)) $display("FAIL arst_pre flags got %b", act_flags());
    else passes++;
    #2;
    wrst_n = 1'b0;
    #1;
    checks++;
    if (act_flags() !== rst_fl) $display("FAIL arst_immediate flags got %b want %b", act_flags(), rst_fl);
    else passes++;
    @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    #1;
    checks++;
    if (act_flags() !== rst_fl) $display("FAIL arst_release flags got %b want %b", act_flags(), rst_fl);
    else passes++;
    cycle(1'b1, 8'h77, 1'b0);
    checks++;
    if (bus.rdata !== 8'h77) $display("FAIL arst_push_rdata got %h want 77", bus.rdata);
    else passes++;
    checks++;
    if (act_flags() !== exp_flags(0, 1, 0, 0)) $display("FAIL arst_push flags got %b", act_flags());
    else passes++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
